id_stage_decoder: RTL and testbench

- Registered, parametrised instruction-decode stage for the RV32I/RV64I pipeline, sitting between IF and EX.
- Decodes all six base formats (R/I/S/B/U/J) into register indices, an XLEN sign-extended immediate and control flags, and flags illegal encodings.
- Uses a valid/ready handshake on both sides and a 2-entry skid buffer, so upstream stalls never see a combinational path from out_ready.
- Supports a synchronous pipeline flush for branch redirect.

---
 rtl/id_stage_decoder.sv | 186 ++++++++++++++++++
 tb/tb_id_stage_decoder.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_decoder.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_decoder
// Brief    : Registered RV32I/RV64I decode stage with a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_decoder #(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_rd_we,
    output logic            out_illegal
);

    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [6:0] c_F7_MUL  = 7'b0000001;

    localparam logic [2:0] c_FMT_R    = 3'd0;
    localparam logic [2:0] c_FMT_I    = 3'd1;
    localparam logic [2:0] c_FMT_S    = 3'd2;
    localparam logic [2:0] c_FMT_B    = 3'd3;
    localparam logic [2:0] c_FMT_U    = 3'd4;
    localparam logic [2:0] c_FMT_J    = 3'd5;
    localparam logic [2:0] c_FMT_NONE = 3'd7;

    localparam int c_REC_W = XLEN + 32 + XLEN + 3 + 4;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [2:0]      w_fmt_raw;
    logic [2:0]      w_fmt;
    logic [XLEN-1:0] w_imm_raw;
    logic [XLEN-1:0] w_imm;
    logic            w_bad;
    logic            w_illegal;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_rd_we;

    assign w_opcode = in_instr[6:0];
    assign w_rd     = in_instr[11:7];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];

    always_comb begin
        w_fmt_raw = c_FMT_NONE;
        w_imm_raw = '0;
        w_bad     = 1'b0;
        case (w_opcode)
            c_OP_OP: begin
                w_fmt_raw = c_FMT_R;
                if (!((w_funct7 == c_F7_BASE) || (w_funct7 == c_F7_ALT) ||
                      (EN_M && (w_funct7 == c_F7_MUL))))
                    w_bad = 1'b1;
                // Only SUB and SRA use the alternate funct7
                if ((w_funct7 == c_F7_ALT) && (w_funct3 != 3'b000) && (w_funct3 != 3'b101))
                    w_bad = 1'b1;
            end
            c_OP_IMM: begin
                w_fmt_raw = c_FMT_I;
                w_imm_raw = XLEN'($signed(in_instr[31:20]));
                if ((w_funct3 == 3'b001) && (w_funct7 != c_F7_BASE))
                    w_bad = 1'b1;
                if ((w_funct3 == 3'b101) && (w_funct7 != c_F7_BASE) && (w_funct7 != c_F7_ALT))
                    w_bad = 1'b1;
            end
            c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM: begin
                w_fmt_raw = c_FMT_I;
                w_imm_raw = XLEN'($signed(in_instr[31:20]));
            end
            c_OP_STORE: begin
                w_fmt_raw = c_FMT_S;
                w_imm_raw = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            end
            c_OP_BRANCH: begin
                w_fmt_raw = c_FMT_B;
                w_imm_raw = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                           in_instr[11:8], 1'b0}));
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_fmt_raw = c_FMT_U;
                w_imm_raw = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            c_OP_JAL: begin
                w_fmt_raw = c_FMT_J;
                w_imm_raw = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                           in_instr[30:21], 1'b0}));
            end
            default: w_bad = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11)
            w_bad = 1'b1;
    end

    assign w_illegal  = w_bad;
    assign w_fmt      = w_bad ? c_FMT_NONE : w_fmt_raw;
    assign w_imm      = w_bad ? '0 : w_imm_raw;
    assign w_rs1_used = (w_fmt == c_FMT_R) || (w_fmt == c_FMT_I) ||
                        (w_fmt == c_FMT_S) || (w_fmt == c_FMT_B);
    assign w_rs2_used = (w_fmt == c_FMT_R) || (w_fmt == c_FMT_S) || (w_fmt == c_FMT_B);
    assign w_rd_we    = ((w_fmt == c_FMT_R) || (w_fmt == c_FMT_I) ||
                         (w_fmt == c_FMT_U) || (w_fmt == c_FMT_J)) && (w_rd != 5'd0);

    logic [c_REC_W-1:0] w_rec;
    logic [c_REC_W-1:0] r_slot [2];
    logic [1:0]         r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_wr_slot;
    logic [31:0]        w_head_instr;

    assign w_rec = {in_pc, in_instr, w_imm, w_fmt, w_rs1_used, w_rs2_used, w_rd_we, w_illegal};

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    // Slot 0 is always the head; a pop shifts slot 1 forward
    assign w_wr_slot = w_pop ? (r_count == 2'd2) : (r_count == 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= 2'd0;
            r_slot[0] <= '0;
            r_slot[1] <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop && (r_count == 2'd2))
                r_slot[0] <= r_slot[1];
            if (w_push) begin
                if (w_wr_slot)
                    r_slot[1] <= w_rec;
                else
                    r_slot[0] <= w_rec;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign {out_pc, w_head_instr, out_imm, out_fmt,
            out_rs1_used, out_rs2_used, out_rd_we, out_illegal} = r_slot[0];

    assign out_opcode = w_head_instr[6:0];
    assign out_rd     = w_head_instr[11:7];
    assign out_funct3 = w_head_instr[14:12];
    assign out_rs1    = w_head_instr[19:15];
    assign out_rs2    = w_head_instr[24:20];
    assign out_funct7 = w_head_instr[31:25];

endmodule
`default_nettype wire

// File: tb/tb_id_stage_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_decoder
// Brief    : Self-checking bench for id_stage_decoder (RV32 base and RV64+M).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage_decoder;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        rs1u;
        logic        rs2u;
        logic        rdwe;
        logic        ill;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;

    logic        rdy32, vld32, rdy64, vld64;
    logic [31:0] o32_pc, o32_imm;
    logic [63:0] o64_pc, o64_imm;
    logic [6:0]  o32_opcode, o32_funct7, o64_opcode, o64_funct7;
    logic [4:0]  o32_rd, o32_rs1, o32_rs2, o64_rd, o64_rs1, o64_rs2;
    logic [2:0]  o32_funct3, o32_fmt, o64_funct3, o64_fmt;
    logic        o32_rs1_used, o32_rs2_used, o32_rd_we, o32_illegal;
    logic        o64_rs1_used, o64_rs2_used, o64_rd_we, o64_illegal;

    int checks = 0;
    int errors = 0;
    logic [95:0] q[$];

    always #5 clk = ~clk;

    id_stage_decoder #(.XLEN(32), .EN_M(1'b0)) d32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(vld32), .out_ready(out_ready), .out_pc(o32_pc),
        .out_opcode(o32_opcode), .out_rd(o32_rd), .out_funct3(o32_funct3),
        .out_rs1(o32_rs1), .out_rs2(o32_rs2), .out_funct7(o32_funct7),
        .out_imm(o32_imm), .out_fmt(o32_fmt), .out_rs1_used(o32_rs1_used),
        .out_rs2_used(o32_rs2_used), .out_rd_we(o32_rd_we), .out_illegal(o32_illegal)
    );

    id_stage_decoder #(.XLEN(64), .EN_M(1'b1)) d64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(vld64), .out_ready(out_ready), .out_pc(o64_pc),
        .out_opcode(o64_opcode), .out_rd(o64_rd), .out_funct3(o64_funct3),
        .out_rs1(o64_rs1), .out_rs2(o64_rs2), .out_funct7(o64_funct7),
        .out_imm(o64_imm), .out_fmt(o64_fmt), .out_rs1_used(o64_rs1_used),
        .out_rs2_used(o64_rs2_used), .out_rd_we(o64_rd_we), .out_illegal(o64_illegal)
    );

    rec_t act32, act64;
    assign act32 = {32'b0, o32_pc, o32_funct7, o32_rs2, o32_rs1, o32_funct3, o32_rd, o32_opcode,
                    32'b0, o32_imm, o32_fmt, o32_rs1_used, o32_rs2_used, o32_rd_we, o32_illegal};
    assign act64 = {o64_pc, o64_funct7, o64_rs2, o64_rs1, o64_funct3, o64_rd, o64_opcode,
                    o64_imm, o64_fmt, o64_rs1_used, o64_rs2_used, o64_rd_we, o64_illegal};

    // Reference decoder: immediates built as signed integers from the field values
    function automatic rec_t model(input logic [31:0] ins, input logic [63:0] pc,
                                   input bit x64, input bit enm);
        rec_t   r;
        longint imm;
        int     fmt;
        bit     ill;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        imm = 0;
        ill = 1'b0;
        fmt = 7;
        case (op)
            7'h33: begin
                fmt = 0;
                ill = !(f7 == 7'h00 || f7 == 7'h20 || (enm && f7 == 7'h01)) ||
                      (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5);
            end
            7'h13: begin
                fmt = 1;
                ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'h03, 7'h67, 7'h73: fmt = 1;
            7'h23: fmt = 2;
            7'h63: fmt = 3;
            7'h37, 7'h17: fmt = 4;
            7'h6f: fmt = 5;
            default: ill = 1'b1;
        endcase
        if (ins[1:0] != 2'b11)
            ill = 1'b1;
        case (fmt)
            1: imm = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
            2: imm = longint'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
            3: imm = longint'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2 - (ins[31] ? 8192 : 0);
            4: imm = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'h1_0000_0000 : 64'h0);
            5: imm = longint'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2
                     - (ins[31] ? 2097152 : 0);
            default: imm = 0;
        endcase
        if (ill) begin
            fmt = 7;
            imm = 0;
        end
        r.pc    = x64 ? pc : {32'b0, pc[31:0]};
        r.instr = ins;
        r.imm   = x64 ? imm : {32'b0, imm[31:0]};
        r.fmt   = 3'(fmt);
        r.rs1u  = (fmt <= 3);
        r.rs2u  = (fmt == 0 || fmt == 2 || fmt == 3);
        r.rdwe  = (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5) && (ins[11:7] != 5'd0);
        r.ill   = ill;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 11))
            0: ins[6:0] = 7'h33;  1: ins[6:0] = 7'h13;  2: ins[6:0] = 7'h03;
            3: ins[6:0] = 7'h67;  4: ins[6:0] = 7'h73;  5: ins[6:0] = 7'h23;
            6: ins[6:0] = 7'h63;  7: ins[6:0] = 7'h37;  8: ins[6:0] = 7'h17;
            9: ins[6:0] = 7'h6f;  default: ;
        endcase
        case ($urandom_range(0, 4))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            2: ins[31:25] = 7'h01;
            default: ;
        endcase
        return ins;
    endfunction

    // One clock: track the expected buffer contents from the handshake rules
    task automatic advance();
        bit push, pop;
        push = in_valid && (q.size() < 2);
        pop  = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back({in_pc, in_instr});
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({vld32, vld64, rdy32, rdy64} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_handshake: got v32=%0b v64=%0b r32=%0b r64=%0b want 0 0 1 1",
                     vld32, vld64, rdy32, rdy64);
        end
        checks++;
        if (act32 !== '0 || act64 !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h / %h want 0", act32, act64);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 64'h1000;
        advance();
        in_valid = 1'b0;
        checks++;
        if (vld32 !== 1'b1 || o32_fmt !== 3'd1 || o32_rd !== 5'd1 || o32_rs1 !== 5'd0) begin
            errors++;
            $display("FAIL addi_fields: got v=%0b fmt=%0d rd=%0d rs1=%0d want 1 1 1 0",
                     vld32, o32_fmt, o32_rd, o32_rs1);
        end
        checks++;
        if (o32_imm !== 32'hFFFFFFFF || o32_rd_we !== 1'b1 || o32_rs2_used !== 1'b0 ||
            o32_pc !== 32'h1000) begin
            errors++;
            $display("FAIL addi_imm: got imm=%h we=%0b rs2u=%0b pc=%h want ffffffff 1 0 1000",
                     o32_imm, o32_rd_we, o32_rs2_used, o32_pc);
        end
        advance();
    endtask

    task automatic test_lui_beq();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h123452B7;
        advance();
        in_instr = 32'hFE000EE3;
        checks++;
        if (vld32 !== 1'b1 || o32_imm !== 32'h12345000 || o32_fmt !== 3'd4 || o32_rd !== 5'd5) begin
            errors++;
            $display("FAIL lui: got v=%0b imm=%h fmt=%0d rd=%0d want 1 12345000 4 5",
                     vld32, o32_imm, o32_fmt, o32_rd);
        end
        advance();
        in_valid = 1'b0;
        checks++;
        if (vld32 !== 1'b1 || o32_imm !== 32'hFFFFFFFC || o32_fmt !== 3'd3 || o32_rd_we !== 1'b0 ||
            o32_rs1_used !== 1'b1 || o32_rs2_used !== 1'b1) begin
            errors++;
            $display("FAIL beq: got v=%0b imm=%h fmt=%0d we=%0b rs1u=%0b rs2u=%0b want 1 fffffffc 3 0 1 1",
                     vld32, o32_imm, o32_fmt, o32_rd_we, o32_rs1_used, o32_rs2_used);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [3];
        seq[0] = 32'h00100093;
        seq[1] = 32'h00208133;
        seq[2] = 32'h00312023;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_instr = seq[i];
            if (i < 2) advance();
        end
        checks++;
        if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %0b/%0b want 0", rdy32, rdy64);
        end
        advance();
        checks++;
        if (rdy32 !== 1'b0 || o32_opcode !== seq[0][6:0] || act32.instr !== seq[0]) begin
            errors++;
            $display("FAIL held: got ready=%0b head=%h want 0 %h", rdy32, act32.instr, seq[0]);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vld32 !== 1'b1 || act32.instr !== seq[i] || act64.instr !== seq[i]) begin
                errors++;
                $display("FAIL drain_order[%0d]: got v=%0b %h/%h want %h", i, vld32,
                         act32.instr, act64.instr, seq[i]);
            end
            advance();
            if (i == 1) in_valid = 1'b0;
        end
        checks++;
        if (vld32 !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got %0b want 0", vld32);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00000013;
        advance();
        advance();
        in_instr = 32'h0FF00513;
        flush    = 1'b1;
        advance();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({vld32, vld64, rdy32, rdy64} !== 4'b0011) begin
            errors++;
            $display("FAIL flush: got v=%0b%0b r=%0b%0b want 00 11", vld32, vld64, rdy32, rdy64);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            checks++;
            if (vld32 !== 1'b0 || vld64 !== 1'b0) begin
                errors++;
                $display("FAIL flush_leak[%0d]: got v=%0b/%0b instr=%h want 0", i, vld32, vld64,
                         act32.instr);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] seq [3];
        seq[0] = 32'h00000000;
        seq[1] = 32'h02000033;
        seq[2] = 32'h40001013;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = seq[i];
            advance();
            in_valid = 1'b0;
            checks++;
            if (vld32 !== 1'b1 || o32_illegal !== 1'b1 || o32_fmt !== 3'd7 || o32_imm !== 32'h0 ||
                o32_rd_we !== 1'b0 || o32_rs1_used !== 1'b0 || act32.instr !== seq[i]) begin
                errors++;
                $display("FAIL illegal[%0d]: got v=%0b ill=%0b fmt=%0d imm=%h we=%0b raw=%h want 1 1 7 0 0 %h",
                         i, vld32, o32_illegal, o32_fmt, o32_imm, o32_rd_we, act32.instr, seq[i]);
            end
            if (i == 1) begin
                checks++;
                if (o64_illegal !== 1'b0 || o64_fmt !== 3'd0 || o64_rs2_used !== 1'b1) begin
                    errors++;
                    $display("FAIL mul_legal: got ill=%0b fmt=%0d rs2u=%0b want 0 0 1",
                             o64_illegal, o64_fmt, o64_rs2_used);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        rec_t e32, e64;
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom};
            checks++;
            if ({vld32, vld64} !== {2{q.size() != 0}} || {rdy32, rdy64} !== {2{q.size() != 2}}) begin
                errors++;
                $display("FAIL rand_hs[%0d]: got v=%0b%0b r=%0b%0b want size=%0d", n, vld32, vld64,
                         rdy32, rdy64, q.size());
            end
            if (q.size() != 0) begin
                e32 = model(q[0][31:0], q[0][95:32], 1'b0, 1'b0);
                e64 = model(q[0][31:0], q[0][95:32], 1'b1, 1'b1);
                checks++;
                if (act32 !== e32) begin
                    errors++;
                    $display("FAIL rand_rv32[%0d]: got %h want %h", n, act32, e32);
                end
                checks++;
                if (act64 !== e64) begin
                    errors++;
                    $display("FAIL rand_rv64[%0d]: got %h want %h", n, act64, e64);
                end
            end
            advance();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        advance();
        advance();
    endtask

    task automatic test_rv64_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h800000B7;
        in_pc     = 64'h8000_0000_0000_0040;
        advance();
        checks++;
        if (vld64 !== 1'b1 || o64_imm !== 64'hFFFFFFFF80000000 || o64_fmt !== 3'd4 ||
            o64_pc !== 64'h8000_0000_0000_0040) begin
            errors++;
            $display("FAIL lui64: got v=%0b imm=%h fmt=%0d pc=%h want 1 ffffffff80000000 4 8000000000000040",
                     vld64, o64_imm, o64_fmt, o64_pc);
        end
        advance();
        in_valid = 1'b0;
        checks++;
        if (rdy64 !== 1'b0 || rdy32 !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_full: got %0b/%0b want 0", rdy64, rdy32);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({vld32, vld64, rdy32, rdy64} !== 4'b0011) begin
            errors++;
            $display("FAIL async_reset: got v=%0b%0b r=%0b%0b want 00 11", vld32, vld64, rdy32, rdy64);
        end
        q.delete();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lui_beq();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_random();
        test_rv64_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
